// File: rtl/dump_tx_pkg.sv
// Shared types and constants for the capture-dump UART transmitter.
package dump_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEFAULT_BAUD_DIV = 2604;
  localparam int FRAME_BITS       = 10;

endpackage

// File: rtl/dump_uart_tx_if.sv
// Dump handshake between the capture unit (master) and the UART transmitter (slave).
interface dump_uart_tx_if;
  logic [7:0] dump_data;
  logic       send_dump;
  logic       dump_sent;
  logic       busy;

  modport master (output dump_data, output send_dump, input dump_sent, input busy);
  modport slave  (input dump_data, input send_dump, output dump_sent, output busy);
endinterface

// File: rtl/dump_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last count of each period.
module dump_baud_gen #(
  parameter int BAUD_DIV = 2604
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr || count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == LAST);
endmodule

// File: rtl/dump_uart_tx.sv
// 8N1 serial transmitter for the capture dump; one byte per accepted send_dump,
// dump_sent pulses once the stop bit has been fully driven.
module dump_uart_tx
  import dump_tx_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic          clk,
  input  logic          rst_n,
  dump_uart_tx_if.slave dump,
  output logic          TX
);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 3);

  tx_state_t  state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic       tx_reg, tx_next;
  logic       busy_reg, busy_next;
  logic       sent_reg, sent_next;
  logic       baud_clr;
  logic       tick;

  dump_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      sent_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      sent_reg    <= sent_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    baud_clr     = 1'b0;
    sent_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (dump.send_dump) begin
          state_next   = START;
          shift_next   = dump.dump_data;
          bit_cnt_next = '0;
          baud_clr     = 1'b1;
        end
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          sent_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered, so they are derived from where the FSM is heading.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign TX             = tx_reg;
  assign dump.busy      = busy_reg;
  assign dump.dump_sent = sent_reg;
endmodule

// File: tb/tb_dump_uart_tx.sv
// Self-checking bench for dump_uart_tx: a cycle-indexed frame model checked every
// cycle, directed scenarios with literal expectations, and a randomized phase.
module tb_dump_uart_tx;
  localparam int B = 4;
  localparam int HIST = 8192;

  logic clk;
  logic rst_n;
  logic tx;
  dump_uart_tx_if dif();

  dump_uart_tx #(.BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dump  (dif.slave),
    .TX    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: the most recently accepted frame and the cycle it was accepted in.
  bit       m_active = 1'b0;
  int       m_fs = 0;
  bit [7:0] m_byte = 8'h00;

  bit tx_hist [HIST];
  int sent_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_out(input int c, output logic etx, output logic ebusy,
                                    output logic esent);
    int k;
    int idx;
    etx = 1'b1; ebusy = 1'b0; esent = 1'b0;
    if (m_active) begin
      k = c - m_fs;
      if (k >= 1 && k <= 10*B) begin
        ebusy = 1'b1;
        idx = (k - 1) / B;
        if (idx == 0)      etx = 1'b0;
        else if (idx <= 8) etx = m_byte[idx-1];
        else               etx = 1'b1;
      end else if (k == 10*B + 1) begin
        esent = 1'b1;
      end
    end
  endfunction

  function automatic bit model_busy(input int c);
    int k;
    k = c - m_fs;
    return m_active && k >= 1 && k <= 10*B;
  endfunction

  // Acceptance decided from the frame timeline, then advance the cycle number.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
    end else if (dif.send_dump && !model_busy(cyc)) begin
      m_active = 1'b1;
      m_fs     = cyc;
      m_byte   = dif.dump_data;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    logic etx, ebusy, esent;
    if (!rst_n) begin
      etx = 1'b1; ebusy = 1'b0; esent = 1'b0;
    end else begin
      model_out(cyc, etx, ebusy, esent);
    end
    check("tx", tx, etx);
    check("busy", dif.busy, ebusy);
    check("dump_sent", dif.dump_sent, esent);
    if (cyc < HIST) tx_hist[cyc] = tx;
    if (dif.dump_sent) sent_q.push_back(cyc);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int c);
    c = cyc;
    dif.send_dump = 1'b1;
    dif.dump_data = b;
    wait_cycles(1);
    dif.send_dump = 1'b0;
  endtask

  function automatic logic [7:0] decode(input int fs);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = tx_hist[fs + 1 + B*(i+1) + B/2];
    return d;
  endfunction

  initial begin
    int c0, c1, c2;
    rst_n = 1'b0;
    dif.send_dump = 1'b0;
    dif.dump_data = 8'h00;
    wait_cycles(3);
    rst_n = 1'b1;

    // Idle line after reset
    sent_q.delete();
    wait_cycles(100);
    check("idle_sent_count", sent_q.size(), 0);

    // Single byte 0xA5
    send_byte(8'hA5, c0);
    wait_cycles(45);
    check("a5_decode", decode(c0), 8'hA5);
    check("a5_start", tx_hist[c0+1], 1'b0);
    check("a5_start_end", tx_hist[c0+B], 1'b0);
    check("a5_stop", tx_hist[c0+1+9*B], 1'b1);
    check("a5_sent_count", sent_q.size(), 1);
    check("a5_sent_cycle", (sent_q.size() == 1) ? sent_q[0] - c0 : -1, 41);

    // Back-to-back 0x00 then 0xFF in the dump_sent cycle
    sent_q.delete();
    send_byte(8'h00, c1);
    wait_cycles(40);
    send_byte(8'hFF, c2);
    wait_cycles(45);
    check("b2b_second_accept", c2 - c1, 41);
    check("b2b_last_data", tx_hist[c1+36], 1'b0);
    check("b2b_stop", tx_hist[c1+40], 1'b1);
    check("b2b_idle_gap", tx_hist[c1+41], 1'b1);
    check("b2b_second_start", tx_hist[c1+42], 1'b0);
    check("b2b_decode0", decode(c1), 8'h00);
    check("b2b_decode1", decode(c2), 8'hFF);
    check("b2b_sent_count", sent_q.size(), 2);
    check("b2b_sent2_cycle", (sent_q.size() == 2) ? sent_q[1] - c1 : -1, 82);

    // Request while busy is ignored
    sent_q.delete();
    send_byte(8'h3C, c0);
    wait_cycles(9);
    send_byte(8'hC3, c1);
    wait_cycles(45);
    check("ign_decode", decode(c0), 8'h3C);
    check("ign_sent_count", sent_q.size(), 1);

    // dump_data churn after acceptance
    sent_q.delete();
    send_byte(8'h81, c0);
    for (int i = 0; i < 44; i++) begin
      dif.dump_data = 8'($urandom);
      wait_cycles(1);
    end
    check("hold_decode", decode(c0), 8'h81);
    check("hold_sent_count", sent_q.size(), 1);

    // Reset in the middle of a 0x55 frame
    sent_q.delete();
    send_byte(8'h55, c0);
    wait_cycles(16);
    rst_n = 1'b0;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", dif.busy, 1'b0);
    check("rst_sent", dif.dump_sent, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(30);
    check("rst_no_sent", sent_q.size(), 0);
    send_byte(8'h12, c0);
    wait_cycles(45);
    check("post_rst_decode", decode(c0), 8'h12);
    check("post_rst_sent_count", sent_q.size(), 1);

    // Randomized requests, including spurious pulses while busy
    for (int i = 0; i < 600; i++) begin
      dif.send_dump = ($urandom_range(0, 9) == 0);
      dif.dump_data = 8'($urandom);
      wait_cycles(1);
    end
    dif.send_dump = 1'b0;
    wait_cycles(45);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
